// File: rtl/trig_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : trig_gen_if
// Description : Control/status bundle between the register file and the
//               periodic trigger generator. The master modport is the
//               register-file side (drives configuration and start/stop);
//               the slave modport is the generator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface trig_gen_if #(
  parameter int PERIOD_W = 26,
  parameter int WIDTH_W  = 16,
  parameter int CNT_W    = 16
);
  logic                enable_i;
  logic                one_shot_i;
  logic [PERIOD_W-1:0] period_i;
  logic [WIDTH_W-1:0]  width_i;
  logic                TRIG_OUT_B;
  logic                busy_o;
  logic [CNT_W-1:0]    trig_count_o;
  logic                cfg_err_o;

  modport master (
    output enable_i, one_shot_i, period_i, width_i,
    input  TRIG_OUT_B, busy_o, trig_count_o, cfg_err_o
  );

  modport slave (
    input  enable_i, one_shot_i, period_i, width_i,
    output TRIG_OUT_B, busy_o, trig_count_o, cfg_err_o
  );
endinterface
`default_nettype wire

// File: rtl/trig_gen.sv
`default_nettype none
// ============================================================================
// Module      : trig_gen
// Description : Periodic external-trigger generator. Emits an active-low
//               pulse train (or a single pulse) of programmable period and
//               width. Configuration is latched only at each pulse start.
//               All outputs are registered one stage after the FSM state, so
//               a start request sampled at edge N drives the line low after
//               edge N+1; every output shares that same alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module trig_gen #(
  parameter int PERIOD_W = 26,
  parameter int WIDTH_W  = 16,
  parameter int CNT_W    = 16
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  trig_gen_if.slave  trig_if
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PERIOD_W-1:0] r_phase;      // cycles since the falling edge
  logic [PERIOD_W-1:0] w_phase_nxt;
  logic [PERIOD_W-1:0] r_period;     // latched period for the current pulse
  logic [WIDTH_W-1:0]  r_width;      // latched effective width
  logic                r_free;       // current pulse belongs to a free-running train
  logic                r_cfg_err;
  logic                r_trig_b;
  logic                r_busy;
  logic [CNT_W-1:0]    r_count;

  logic                w_load;
  logic                w_err_set;
  logic                w_start_ok;
  logic                w_start_err;
  logic [WIDTH_W-1:0]  w_width_eff;
  logic                w_w_zero;
  logic                w_p_small;
  logic                w_w_clip;

  // Legality of a pulse start against the live config; enable_i selects free-running rules
  always_comb begin
    w_w_zero    = (trig_if.width_i == '0);
    w_p_small   = (trig_if.period_i < PERIOD_W'(2));
    w_w_clip    = (PERIOD_W'(trig_if.width_i) >= trig_if.period_i);
    w_width_eff = trig_if.width_i;
    if (trig_if.enable_i) begin
      w_start_ok  = !w_w_zero && !w_p_small;
      w_start_err = w_w_zero || w_p_small || w_w_clip;
      if (w_w_clip) begin
        w_width_eff = WIDTH_W'(trig_if.period_i - PERIOD_W'(1));
      end
    end else begin
      // a lone one-shot has no period, so only the width matters
      w_start_ok  = !w_w_zero;
      w_start_err = w_w_zero;
    end
  end

  // Next-state logic: pulse sequencing and the phase counter
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase + PERIOD_W'(1);
    w_load      = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_phase_nxt = '0;
        if (trig_if.enable_i || trig_if.one_shot_i) begin
          w_err_set = w_start_err;
          if (w_start_ok) begin
            w_state_nxt = S_ASSERT;
            w_load      = 1'b1;
          end
        end
      end
      S_ASSERT: begin
        // the pulse always runs to full width; enable only decides what follows
        if (r_phase == PERIOD_W'(r_width) - PERIOD_W'(1)) begin
          if (r_free && trig_if.enable_i) begin
            w_state_nxt = S_HOLDOFF;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_HOLDOFF: begin
        if (!trig_if.enable_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_phase == r_period - PERIOD_W'(1)) begin
          w_err_set = w_start_err;
          if (w_start_ok) begin
            w_state_nxt = S_ASSERT;
            w_phase_nxt = '0;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, config latch and sticky error flag
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_period  <= '0;
      r_width   <= '0;
      r_free    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      if (w_load) begin
        r_period <= trig_if.period_i;
        r_width  <= w_width_eff;
        r_free   <= trig_if.enable_i;
      end
      if (w_err_set) begin
        r_cfg_err <= 1'b1;
      end
    end
  end

  // Registered outputs, all one stage behind the state so they stay mutually aligned
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_trig_b <= 1'b1;
      r_busy   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_trig_b <= (r_state != S_ASSERT);
      r_busy   <= (r_state != S_IDLE);
      if ((r_state == S_ASSERT) && (r_phase == '0)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign trig_if.TRIG_OUT_B   = r_trig_b;
  assign trig_if.busy_o       = r_busy;
  assign trig_if.trig_count_o = r_count;
  assign trig_if.cfg_err_o    = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_trig_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_trig_gen
// Description : Directed self-checking bench for trig_gen. Records falling
//               edge cycle numbers, low-run lengths and busy cycles of the
//               trigger line and compares them to hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trig_gen;

  localparam int PERIOD_W = 26;
  localparam int WIDTH_W  = 16;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  trig_gen_if #(.PERIOD_W(PERIOD_W), .WIDTH_W(WIDTH_W), .CNT_W(CNT_W)) bus ();

  trig_gen #(.PERIOD_W(PERIOD_W), .WIDTH_W(WIDTH_W), .CNT_W(CNT_W)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .trig_if   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int falls[$];
  int lows[$];
  int low_run;
  int busy_cycles;
  logic prev_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock; sample 1 ns after the edge and record the trigger waveform
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_b === 1'b1 && bus.TRIG_OUT_B === 1'b0) falls.push_back(cyc);
    if (bus.TRIG_OUT_B === 1'b0) begin
      low_run++;
    end else if (low_run > 0) begin
      lows.push_back(low_run);
      low_run = 0;
    end
    if (bus.busy_o === 1'b1) busy_cycles++;
    prev_b = bus.TRIG_OUT_B;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input string tag);
    rst            = 1'b1;
    bus.enable_i   = 1'b0;
    bus.one_shot_i = 1'b0;
    bus.period_i   = '0;
    bus.width_i    = '0;
    ticks(2);
    chk({tag, "_rst_trig"},  32'(bus.TRIG_OUT_B),   32'd1);
    chk({tag, "_rst_busy"},  32'(bus.busy_o),       32'd0);
    chk({tag, "_rst_count"}, 32'(bus.trig_count_o), 32'd0);
    chk({tag, "_rst_err"},   32'(bus.cfg_err_o),    32'd0);
    rst = 1'b0;
    falls.delete();
    lows.delete();
    low_run     = 0;
    busy_cycles = 0;
    prev_b      = 1'b1;
  endtask

  initial begin
    // ---------------- free-run 10/3, five pulses ----------------
    do_reset("fr");
    bus.period_i = 26'd10;
    bus.width_i  = 16'd3;
    bus.enable_i = 1'b1;
    tick();
    chk("fr_latency_high", 32'(bus.TRIG_OUT_B), 32'd1);
    tick();
    chk("fr_first_low",   32'(bus.TRIG_OUT_B),   32'd0);
    chk("fr_first_busy",  32'(bus.busy_o),       32'd1);
    chk("fr_first_count", 32'(bus.trig_count_o), 32'd1);
    ticks(40);
    ticks(5);
    bus.enable_i = 1'b0;
    ticks(20);
    chk("fr_falls", 32'(falls.size()), 32'd5);
    for (int i = 1; i < falls.size(); i++) chk("fr_period", 32'(falls[i] - falls[i-1]), 32'd10);
    for (int i = 0; i < lows.size(); i++) chk("fr_width", 32'(lows[i]), 32'd3);
    chk("fr_count", 32'(bus.trig_count_o), 32'd5);
    chk("fr_err",   32'(bus.cfg_err_o),    32'd0);
    chk("fr_idle_busy", 32'(bus.busy_o),   32'd0);

    // ---------------- one-shot, second strobe ignored ----------------
    do_reset("os");
    bus.period_i   = 26'd10;
    bus.width_i    = 16'd4;
    bus.one_shot_i = 1'b1;
    tick();
    bus.one_shot_i = 1'b0;
    tick();
    chk("os_low", 32'(bus.TRIG_OUT_B), 32'd0);
    bus.one_shot_i = 1'b1;
    tick();
    bus.one_shot_i = 1'b0;
    ticks(15);
    chk("os_falls", 32'(falls.size()), 32'd1);
    chk("os_nlows", 32'(lows.size()),  32'd1);
    if (lows.size() > 0) chk("os_width", 32'(lows[0]), 32'd4);
    chk("os_busy_cycles", 32'(busy_cycles),         32'd4);
    chk("os_count",       32'(bus.trig_count_o),    32'd1);
    chk("os_err",         32'(bus.cfg_err_o),       32'd0);

    // ---------------- disable on cycle 2 of the pulse ----------------
    do_reset("dis");
    bus.period_i = 26'd20;
    bus.width_i  = 16'd8;
    bus.enable_i = 1'b1;
    ticks(3);
    bus.enable_i = 1'b0;
    ticks(40);
    chk("dis_falls", 32'(falls.size()), 32'd1);
    if (lows.size() > 0) chk("dis_width", 32'(lows[0]), 32'd8);
    chk("dis_count", 32'(bus.trig_count_o), 32'd1);
    chk("dis_busy",  32'(bus.busy_o),       32'd0);

    // ---------------- width 0 refused ----------------
    do_reset("w0");
    bus.period_i = 26'd10;
    bus.width_i  = 16'd0;
    bus.enable_i = 1'b1;
    ticks(20);
    bus.enable_i = 1'b0;
    tick();
    chk("w0_falls", 32'(falls.size()),      32'd0);
    chk("w0_err",   32'(bus.cfg_err_o),     32'd1);
    chk("w0_count", 32'(bus.trig_count_o),  32'd0);
    chk("w0_busy",  32'(bus.busy_o),        32'd0);

    // ---------------- width >= period clipped to period-1 ----------------
    do_reset("clip");
    bus.period_i = 26'd10;
    bus.width_i  = 16'd12;
    bus.enable_i = 1'b1;
    ticks(2);
    ticks(30);
    bus.enable_i = 1'b0;
    ticks(15);
    chk("clip_falls", 32'(falls.size()), 32'd4);
    for (int i = 1; i < falls.size(); i++) chk("clip_period", 32'(falls[i] - falls[i-1]), 32'd10);
    for (int i = 0; i < lows.size(); i++) chk("clip_width", 32'(lows[i]), 32'd9);
    chk("clip_err", 32'(bus.cfg_err_o), 32'd1);

    // ---------------- period change during holdoff ----------------
    do_reset("chg");
    bus.period_i = 26'd10;
    bus.width_i  = 16'd3;
    bus.enable_i = 1'b1;
    ticks(2);
    ticks(5);
    bus.period_i = 26'd16;
    ticks(37);
    bus.enable_i = 1'b0;
    ticks(20);
    chk("chg_falls", 32'(falls.size()), 32'd4);
    if (falls.size() == 4) begin
      chk("chg_p0", 32'(falls[1] - falls[0]), 32'd10);
      chk("chg_p1", 32'(falls[2] - falls[1]), 32'd16);
      chk("chg_p2", 32'(falls[3] - falls[2]), 32'd16);
    end

    // ---------------- reset mid-pulse ----------------
    do_reset("rmp");
    bus.period_i = 26'd10;
    bus.width_i  = 16'd12;
    bus.enable_i = 1'b1;
    ticks(3);
    chk("rmp_pre_low",   32'(bus.TRIG_OUT_B),   32'd0);
    chk("rmp_pre_err",   32'(bus.cfg_err_o),    32'd1);
    chk("rmp_pre_count", 32'(bus.trig_count_o), 32'd1);
    rst          = 1'b1;
    bus.enable_i = 1'b0;
    tick();
    chk("rmp_trig",  32'(bus.TRIG_OUT_B),   32'd1);
    chk("rmp_busy",  32'(bus.busy_o),       32'd0);
    chk("rmp_count", 32'(bus.trig_count_o), 32'd0);
    chk("rmp_err",   32'(bus.cfg_err_o),    32'd0);
    rst = 1'b0;
    ticks(5);
    chk("rmp_stay_high", 32'(bus.TRIG_OUT_B), 32'd1);

    // ---------------- 17 pulses wrap a 4-bit counter; enable beats one-shot ----------------
    do_reset("wrap");
    bus.period_i   = 26'd4;
    bus.width_i    = 16'd2;
    bus.enable_i   = 1'b1;
    bus.one_shot_i = 1'b1;
    tick();
    bus.one_shot_i = 1'b0;
    tick();
    ticks(64);
    bus.enable_i = 1'b0;
    ticks(10);
    chk("wrap_falls", 32'(falls.size()),     32'd17);
    chk("wrap_count", 32'(bus.trig_count_o), 32'd1);
    if (falls.size() >= 2) chk("wrap_period", 32'(falls[1] - falls[0]), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trig_gen.md
# trig_gen

Periodic external-trigger generator: drives an active-low trigger pulse train of programmable period and width on the same kind of line that the camera's trigger watchdog monitors. It is the master/initiator end of the external trigger interface and lets one unit pace slave cameras, or loop back onto its own trigger input for self-test. It sits in the sys_clk_i domain next to the register file, which supplies configuration and start/stop control.

## Interface

Parameters:
- PERIOD_W, 26, width of period counter and period_i
- WIDTH_W, 16, width of pulse-width counter and width_i
- CNT_W, 16, width of trig_count_o

Ports:
- sys_clk_i  in  1  system clock (50 MHz nominal)
- sys_rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  level; 1 = free-running pulse train
- one_shot_i  in  1  single-cycle strobe; emit exactly one pulse
- period_i  in  PERIOD_W  cycles between successive falling edges
- width_i  in  WIDTH_W  cycles the output is held low
- TRIG_OUT_B  out  1  trigger output, active low, registered
- busy_o  out  1  1 while in ASSERT or HOLDOFF
- trig_count_o  out  CNT_W  pulses emitted since reset, wraps
- cfg_err_o  out  1  sticky: illegal config seen at a pulse start

## Operation

- Reset values: TRIG_OUT_B=1, busy_o=0, trig_count_o=0, cfg_err_o=0, state=IDLE, counters=0.
- Config sampling: period_i and width_i are latched into internal registers only at a pulse start. Changes mid-pulse or mid-holdoff take effect at the next pulse.
- Legality: width_eff = width_i, except:
  - width_i==0: cfg_err_o set, pulse start refused, state stays IDLE, count unchanged.
  - width_i>=period_i (for a free-running start): width_eff = period_i-1, cfg_err_o set.
  - period_i<2 (for a free-running start): treated as an illegal width; start refused, cfg_err_o set.
  - cfg_err_o clears only on sys_rst_i.
- States:
  - IDLE: TRIG_OUT_B=1. Goes to ASSERT if enable_i=1 or one_shot_i=1 and the config is legal.
  - ASSERT: TRIG_OUT_B=0 for width_eff cycles, then HOLDOFF.
  - HOLDOFF: TRIG_OUT_B=1. The phase counter continues.
    - Free-running: when period_eff cycles have elapsed since the falling edge, start the next pulse if enable_i=1, else go to IDLE.
    - One-shot: go to IDLE after the width ends. No holdoff is enforced for a one-shot started from IDLE.
- Pulses are never truncated. Dropping enable_i mid-ASSERT completes the full width, then the block goes to IDLE at the end of ASSERT, not HOLDOFF.
- one_shot_i while busy_o=1 is ignored (not queued).
- one_shot_i and enable_i both high in IDLE: one pulse starts, and free-running mode is used (enable wins).
- trig_count_o increments by 1 on each falling edge of TRIG_OUT_B, with modulo 2^CNT_W wrap.
- sys_rst_i mid-pulse: TRIG_OUT_B=1 at the next edge, and all state returns to reset values.

## Timing

- All outputs are registered. Start latency: enable_i or one_shot_i sampled high at edge N gives TRIG_OUT_B=0 after edge N+1, i.e. one cycle.
- Low time is exactly width_eff cycles. Falling-edge-to-falling-edge spacing is exactly period_eff cycles in steady state, with no jitter or drift.
- busy_o rises with the falling edge of TRIG_OUT_B and falls in the same cycle the state returns to IDLE.
- trig_count_o updates in the same cycle TRIG_OUT_B goes low.
- Disable latency: enable_i low during HOLDOFF gives IDLE at the next edge, so no further pulse is emitted.

## Test plan

- Reset then free-run:
  - Stimulus: period_i=10, width_i=3, enable_i=1 held for 5 pulses.
  - Required: TRIG_OUT_B low 3 cycles every 10 cycles; first low 1 cycle after enable; trig_count_o=5; cfg_err_o=0.
- One-shot:
  - Stimulus: width_i=4, single one_shot_i strobe, then a second strobe during ASSERT.
  - Required: exactly one 4-cycle low pulse, trig_count_o=1, busy_o high 4 cycles, second strobe ignored.
- Disable mid-pulse:
  - Stimulus: period_i=20, width_i=8; drop enable_i on cycle 2 of ASSERT.
  - Required: full 8-cycle pulse, then IDLE; no further pulse.
- Illegal config:
  - width_i=0 with enable_i=1: no pulse, cfg_err_o=1.
  - After reset, width_i=12, period_i=10: low 9 cycles, period 10, cfg_err_o=1.
- Config change mid-train: change period_i from 10 to 16 during HOLDOFF. The current period stays 10; the following periods are 16.
- Reset mid-pulse and wrap:
  - Stimulus: assert sys_rst_i during ASSERT.
  - Required: TRIG_OUT_B=1 next cycle and all outputs at reset values.
  - Wrap check: with CNT_W=4, 17 pulses give trig_count_o=1.
  - Loopback check: TRIG_OUT_B looped to a watchdog input with period 50000000 produces no watchdog reset.
